// File: rtl/acc_pkg.sv
// acc_pkg: opcode classes, FSM states and flag indices shared by the accumulator sequencer
package acc_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_LDI  = 4'h2;
    localparam logic [3:0] OP_STA  = 4'h3;
    localparam logic [3:0] OP_ALUM = 4'h4;
    localparam logic [3:0] OP_ALUI = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_JZ   = 4'h7;
    localparam logic [3:0] OP_JC   = 4'h8;
    localparam logic [3:0] OP_JN   = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;

    typedef enum logic [2:0] {
        S_FETCH_OP  = 3'd0,
        S_FETCH_ARG = 3'd1,
        S_MEM_RD    = 3'd2,
        S_MEM_WR    = 3'd3,
        S_EXEC      = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    // Every defined class between LDA and JN carries an argument byte
    function automatic logic two_byte(input logic [3:0] c);
        return (c >= OP_LDA) && (c <= OP_JN);
    endfunction

    function automatic logic is_illegal(input logic [3:0] c);
        return (c > OP_JN) && (c != OP_HALT);
    endfunction

    function automatic logic is_mem(input state_t s);
        return (s == S_FETCH_OP) || (s == S_FETCH_ARG) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/acc_mem_port.sv
// acc_mem_port: registered request/address/write-data holder for the shared memory port
module acc_mem_port #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              next_we,
    input  logic [ADDR_W-1:0] next_addr,
    input  logic [7:0]        next_wdata,
    input  logic              ack,
    output logic              req,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        wdata,
    output logic              done
);

    assign done = req & ack;

    // Launch an access on load, hold it stable while waiting, release it once acked
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req   <= 1'b0;
            we    <= 1'b0;
            addr  <= '0;
            wdata <= '0;
        end else if (load) begin
            req   <= 1'b1;
            we    <= next_we;
            addr  <= next_addr;
            wdata <= next_wdata;
        end else if (done) begin
            req <= 1'b0;
            we  <= 1'b0;
        end
    end

endmodule

// File: rtl/acc_sequencer.sv
// acc_sequencer: multi-cycle fetch/execute control unit for the 8-bit accumulator datapath
module acc_sequencer
    import acc_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [2:0]        alu_select,
    input  logic [7:0]        alu_out,
    input  logic              alu_zero,
    input  logic              alu_carry,
    input  logic              alu_neg,
    output logic [7:0]        acc,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        flags,
    output logic              halted,
    output logic              illegal
);

    state_t            state, state_n;
    logic [7:0]        ir, ir_n, opnd, opnd_n, acc_n;
    logic [ADDR_W-1:0] pc_n, addr_n;
    logic [2:0]        flags_n;
    logic [3:0]        cls;
    logic              done, load, take_jump;

    assign cls        = ir[7:4];
    assign alu_a      = acc;
    assign alu_b      = opnd;
    assign alu_select = (state == S_EXEC) ? ir[2:0] : 3'd0;
    assign halted     = (state == S_HALT);
    assign illegal    = (state == S_EXEC) && is_illegal(cls);
    assign take_jump  = (cls == OP_JMP) || (cls == OP_JZ && flags[FLAG_Z]) ||
                        (cls == OP_JC && flags[FLAG_C]) || (cls == OP_JN && flags[FLAG_N]);

    acc_mem_port #(.ADDR_W(ADDR_W)) u_port (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .next_we   (state_n == S_MEM_WR),
        .next_addr (addr_n),
        .next_wdata(acc_n),
        .ack       (mem_ack),
        .req       (mem_req),
        .we        (mem_we),
        .addr      (mem_addr),
        .wdata     (mem_wdata),
        .done      (done)
    );

    // Architectural registers and state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_FETCH_OP;
            pc    <= RESET_PC;
            ir    <= '0;
            opnd  <= '0;
            acc   <= '0;
            flags <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            ir    <= ir_n;
            opnd  <= opnd_n;
            acc   <= acc_n;
            flags <= flags_n;
        end
    end

    // Next state, register updates, and the address of the next memory access
    always_comb begin
        state_n = state;
        pc_n    = pc;
        ir_n    = ir;
        opnd_n  = opnd;
        acc_n   = acc;
        flags_n = flags;
        case (state)
            S_FETCH_OP: if (done) begin
                ir_n    = mem_rdata;
                pc_n    = pc + ADDR_W'(1);
                state_n = two_byte(mem_rdata[7:4]) ? S_FETCH_ARG : S_EXEC;
            end
            S_FETCH_ARG: if (done) begin
                opnd_n  = mem_rdata;
                pc_n    = pc + ADDR_W'(1);
                state_n = (cls == OP_LDA || cls == OP_ALUM) ? S_MEM_RD :
                          (cls == OP_STA) ? S_MEM_WR : S_EXEC;
            end
            S_MEM_RD: if (done) begin
                opnd_n  = mem_rdata;
                state_n = S_EXEC;
            end
            S_MEM_WR: if (done) state_n = S_FETCH_OP;
            S_EXEC: begin
                state_n = (cls == OP_HALT) ? S_HALT : S_FETCH_OP;
                if (cls == OP_LDA || cls == OP_LDI) acc_n = opnd;
                if (cls == OP_ALUM || cls == OP_ALUI) begin
                    acc_n   = alu_out;
                    flags_n = {alu_neg, alu_carry, alu_zero};
                end
                if (take_jump) pc_n = opnd[ADDR_W-1:0];
            end
            default: state_n = S_HALT;
        endcase
        // A new access starts when the port is idle or the current one completes
        load   = is_mem(state_n) && (!mem_req || done);
        addr_n = (state_n == S_MEM_RD || state_n == S_MEM_WR) ? opnd_n[ADDR_W-1:0] : pc_n;
    end

endmodule

// File: tb/tb_acc_sequencer.sv
// tb_acc_sequencer: directed and random-program checks of acc_sequencer against an ISA-level model
module tb_acc_sequencer;

    logic       clk, rst_n;
    logic       mem_req, mem_we, mem_ack;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [2:0] alu_select, flags;
    logic       alu_zero, alu_carry, alu_neg, halted, illegal;
    logic [7:0] acc, pc;

    logic       mem_req4, mem_we4, mem_ack4;
    logic [3:0] mem_addr4, pc4;
    logic [7:0] mem_wdata4, mem_rdata4, alu_a4, alu_b4, alu_out4, acc4;
    logic [2:0] alu_select4, flags4;
    logic       alu_zero4, alu_carry4, alu_neg4, halted4, illegal4;

    acc_sequencer #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .alu_a(alu_a),
        .alu_b(alu_b), .alu_select(alu_select), .alu_out(alu_out), .alu_zero(alu_zero),
        .alu_carry(alu_carry), .alu_neg(alu_neg), .acc(acc), .pc(pc), .flags(flags),
        .halted(halted), .illegal(illegal)
    );

    acc_sequencer #(.ADDR_W(4), .RESET_PC(4'h0)) dut4 (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req4), .mem_we(mem_we4), .mem_addr(mem_addr4),
        .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata4), .mem_ack(mem_ack4), .alu_a(alu_a4),
        .alu_b(alu_b4), .alu_select(alu_select4), .alu_out(alu_out4), .alu_zero(alu_zero4),
        .alu_carry(alu_carry4), .alu_neg(alu_neg4), .acc(acc4), .pc(pc4), .flags(flags4),
        .halted(halted4), .illegal(illegal4)
    );

    typedef struct {
        logic [7:0] addr;
        logic       we;
        logic [7:0] data;
        logic       op;
        logic [7:0] acc;
        logic [2:0] flags;
    } exp_t;

    int         errors = 0, checks = 0;
    logic [7:0] mem [256];
    logic [7:0] mem4 [16];
    logic [7:0] mmem [256];
    logic [7:0] m_pc, m_acc;
    logic [2:0] m_flags;
    logic       m_halted;
    int         m_ill;
    exp_t       exp_q [$];
    logic [3:0] addr4_q [$];
    logic       busy, rnd, blk, sb_on;
    logic [7:0] blk_addr;
    int         waited, cur_delay, fix_delay, ill_all, ill_cnt;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // External ALU: returns {neg, carry, zero, result}; carry is carry-out / borrow / shifted-out bit
    function automatic logic [10:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
        logic [8:0] r;
        case (s)
            3'd0:    r = {1'b0, a} + {1'b0, b};
            3'd1:    r = {1'b0, a} - {1'b0, b};
            3'd2:    r = {1'b0, a & b};
            3'd3:    r = {1'b0, a | b};
            3'd4:    r = {1'b0, a ^ b};
            3'd5:    r = {a, 1'b0};
            3'd6:    r = {1'b0, ~a};
            default: r = {1'b0, b};
        endcase
        return {r[7], r[8], r[7:0] == 8'h00, r[7:0]};
    endfunction

    function automatic void push(input logic [7:0] a, input logic w, input logic [7:0] d, input logic o);
        exp_t e;
        e.addr = a; e.we = w; e.data = d; e.op = o; e.acc = m_acc; e.flags = m_flags;
        exp_q.push_back(e);
    endfunction

    // Instruction-level interpreter: records the memory accesses each instruction must make
    function automatic void model_run(input int n);
        logic [7:0]  op, arg, b;
        logic [10:0] r;
        logic [3:0]  c;
        for (int k = 0; k < n && !m_halted; k++) begin
            op = mmem[m_pc];
            push(m_pc, 1'b0, 8'h00, 1'b1);
            m_pc++;
            c = op[7:4];
            if (c == 4'hF) m_halted = 1'b1;
            else if (c >= 4'hA) m_ill++;
            else if (c != 4'h0) begin
                arg = mmem[m_pc];
                push(m_pc, 1'b0, 8'h00, 1'b0);
                m_pc++;
                case (c)
                    4'h1: begin push(arg, 1'b0, 8'h00, 1'b0); m_acc = mmem[arg]; end
                    4'h2: m_acc = arg;
                    4'h3: begin push(arg, 1'b1, m_acc, 1'b0); mmem[arg] = m_acc; end
                    4'h4, 4'h5: begin
                        if (c == 4'h4) push(arg, 1'b0, 8'h00, 1'b0);
                        b = (c == 4'h4) ? mmem[arg] : arg;
                        r = alu(m_acc, b, op[2:0]);
                        m_flags = r[10:8];
                        m_acc = r[7:0];
                    end
                    4'h6: m_pc = arg;
                    4'h7: if (m_flags[0]) m_pc = arg;
                    4'h8: if (m_flags[1]) m_pc = arg;
                    4'h9: if (m_flags[2]) m_pc = arg;
                    default: ;
                endcase
            end
        end
        if (!m_halted) push(m_pc, 1'b0, 8'h00, 1'b1);
    endfunction

    // One clock: answer the DUTs at the falling edge, then sample 1 time unit after the rising edge
    task automatic cycle();
        logic [10:0] r;
        exp_t        e;
        @(negedge clk);
        r = alu(alu_a, alu_b, alu_select);
        {alu_neg, alu_carry, alu_zero, alu_out} = r;
        r = alu(alu_a4, alu_b4, alu_select4);
        {alu_neg4, alu_carry4, alu_zero4, alu_out4} = r;
        mem_ack4 = mem_req4;
        mem_rdata4 = mem4[mem_addr4];
        if (mem_req4) addr4_q.push_back(mem_addr4);
        if (mem_req) begin
            if (!busy) begin
                cur_delay = rnd ? int'($urandom_range(0, 2)) : fix_delay;
                waited = 0;
                busy = 1'b1;
            end
            mem_ack = (waited >= cur_delay) && !(blk && mem_addr == blk_addr);
            mem_rdata = mem[mem_addr];
            if (mem_ack) begin
                busy = 1'b0;
                if (mem_we) mem[mem_addr] = mem_wdata;
                if (sb_on && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("access", 64'({mem_addr, mem_we, mem_we ? mem_wdata : 8'h00}),
                        64'({e.addr, e.we, e.we ? e.data : 8'h00}));
                    if (e.op) begin
                        chk("fetch_pc", 64'(pc), 64'(e.addr));
                        chk("fetch_acc", 64'(acc), 64'(e.acc));
                        chk("fetch_flags", 64'(flags), 64'(e.flags));
                    end
                end
            end else waited++;
        end else begin
            mem_ack = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = 8'($urandom);
        end
        @(posedge clk);
        #1;
        if (illegal) ill_all++;
        if (illegal && sb_on && exp_q.size() > 0) ill_cnt++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        cycle();
        busy = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 16; i++) mem4[i] = 8'h00;
        addr4_q.delete();
    endtask

    task automatic run_to_halt(input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            cycle();
            n++;
        end
        chk("halt_reached", 64'(halted), 64'd1);
    endtask

    initial begin
        int         n, i0;
        logic [7:0] a, d, ipc;
        logic [23:0] seq;
        rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00; mem_ack4 = 1'b0; mem_rdata4 = 8'h00;
        {alu_out, alu_zero, alu_carry, alu_neg} = '0;
        {alu_out4, alu_zero4, alu_carry4, alu_neg4} = '0;
        busy = 0; rnd = 0; blk = 0; sb_on = 0; blk_addr = 8'h00;
        waited = 0; cur_delay = 0; fix_delay = 0; ill_all = 0; ill_cnt = 0;

        // Reset state, then LDI 10; ALUI add 20; HALT with zero-wait memory
        do_reset();
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        chk("rst_acc", 64'(acc), 64'd0);
        chk("rst_pc", 64'(pc), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        {mem[0], mem[1], mem[2], mem[3], mem[4]} = {8'h20, 8'h0A, 8'h50, 8'h14, 8'hF0};
        n = 0;
        while (!mem_req && n < 5) begin cycle(); n++; end
        n = 0;
        while (!halted && n < 30) begin cycle(); n++; end
        chk("t1_cycles", 64'(n), 64'd8);
        chk("t1_acc", 64'(acc), 64'd30);
        chk("t1_flags", 64'(flags), 64'd0);
        chk("t1_pc", 64'(pc), 64'd5);
        chk("t1_req_in_halt", 64'(mem_req), 64'd0);

        // LDI 30; ALUI sub 30; JZ 0x10 -> HALT at 0x10 (fall-through also halts, at 0x06)
        do_reset();
        {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6]} =
            {8'h20, 8'h1E, 8'h51, 8'h1E, 8'h70, 8'h10, 8'hF0};
        mem[8'h10] = 8'hF0;
        run_to_halt(40);
        chk("t2_flags", 64'(flags), 64'b001);
        chk("t2_pc", 64'(pc), 64'h11);

        // STA with every access acked on its fourth cycle
        do_reset();
        fix_delay = 3;
        {mem[0], mem[1], mem[2], mem[3], mem[4]} = {8'h20, 8'h5A, 8'h30, 8'h40, 8'hF0};
        n = 0;
        while (!(mem_req && mem_we) && n < 60) begin cycle(); n++; end
        a = mem_addr;
        d = mem_wdata;
        n = 0;
        while (mem_req && mem_we && mem_addr == a && mem_wdata == d && n < 10) begin cycle(); n++; end
        chk("t3_write_cycles", 64'(n), 64'd4);
        chk("t3_write_addr_data", 64'({a, d}), 64'h405A);
        chk("t3_next_fetch", 64'({mem_req, mem_we, mem_addr}), 64'({1'b1, 1'b0, 8'h04}));
        run_to_halt(60);
        chk("t3_mem", 64'(mem[8'h40]), 64'h5A);
        fix_delay = 0;

        // Undefined opcode 0xB0 between an ALUI that sets neg and a HALT
        do_reset();
        {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5]} = {8'h20, 8'h80, 8'h50, 8'h00, 8'hB0, 8'hF0};
        i0 = ill_all;
        ipc = 8'hEE;
        n = 0;
        while (!halted && n < 40) begin
            cycle();
            if (illegal) ipc = pc;
            n++;
        end
        chk("t4_pulses", 64'(ill_all - i0), 64'd1);
        chk("t4_pc_at_pulse", 64'(ipc), 64'd5);
        chk("t4_acc", 64'(acc), 64'h80);
        chk("t4_flags", 64'(flags), 64'b100);
        chk("t4_pc", 64'(pc), 64'd6);

        // Reset while an LDA operand read is left waiting
        do_reset();
        blk = 1'b1;
        blk_addr = 8'h30;
        {mem[0], mem[1], mem[2], mem[3]} = {8'h20, 8'h77, 8'h10, 8'h30};
        n = 0;
        while (!(mem_req && mem_addr == 8'h30) && n < 30) begin cycle(); n++; end
        cycle();
        cycle();
        chk("t5_pending", 64'({mem_req, mem_we, mem_addr}), 64'({1'b1, 1'b0, 8'h30}));
        chk("t5_acc_before", 64'(acc), 64'h77);
        rst_n = 1'b0;
        cycle();
        chk("t5_req", 64'(mem_req), 64'd0);
        chk("t5_pc", 64'(pc), 64'd0);
        chk("t5_acc", 64'(acc), 64'd0);
        blk = 1'b0;

        // 4-bit address instance: JMP 0xF; LDI at 0xF whose argument wraps to address 0
        do_reset();
        {mem4[0], mem4[1], mem4[2], mem4[15]} = {8'h60, 8'h0F, 8'hF0, 8'h20};
        n = 0;
        while (!halted4 && n < 40) begin cycle(); n++; end
        chk("t6_halted", 64'(halted4), 64'd1);
        chk("t6_acc", 64'(acc4), 64'h60);
        chk("t6_pc", 64'(pc4), 64'd3);
        seq = '0;
        for (int i = 0; i < addr4_q.size() && i < 6; i++) seq = {seq[19:0], addr4_q[i]};
        chk("t6_addr_seq", 64'({8'(addr4_q.size()), seq}), 64'({8'd6, 24'h01F012}));

        // Random programs with random ack latency and stray acks, checked access by access
        for (int p = 0; p < 8; p++) begin
            do_reset();
            for (int i = 0; i < 256; i++) begin
                mem[i] = 8'($urandom);
                mmem[i] = mem[i];
            end
            m_pc = 8'h00; m_acc = 8'h00; m_flags = 3'b000; m_halted = 1'b0; m_ill = 0;
            exp_q.delete();
            model_run(40);
            ill_cnt = 0;
            sb_on = 1'b1;
            rnd = 1'b1;
            n = 0;
            while (exp_q.size() > 0 && n < 4000) begin cycle(); n++; end
            sb_on = 1'b0;
            rnd = 1'b0;
            chk("rnd_complete", 64'(exp_q.size()), 64'd0);
            chk("rnd_illegal", 64'(ill_cnt), 64'(m_ill));
            if (m_halted) begin
                cycle();
                cycle();
                cycle();
                chk("rnd_halt", 64'({halted, mem_req}), 64'b10);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/acc_sequencer.md
Name: acc_sequencer

Overview:
- Multi-cycle control unit for the 8-bit accumulator datapath.
- Fetches 1- or 2-byte instructions over a single shared memory port using a req/ack handshake.
- Owns the PC, IR, operand register, accumulator and flag registers, and drives the external alu (operand A = accumulator, operand B = operand register, 3-bit select).
- Writes the alu result and flags back on execute.

Parameters:
- ADDR_W, 8, memory address width; legal range 4..8. Addresses are arg[ADDR_W-1:0].
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active low
- mem_req  out  1  memory access request, registered
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
- mem_addr  out  ADDR_W  access address; valid while mem_req=1
- mem_wdata  out  8  write data (accumulator)
- mem_rdata  in  8  read data; valid in the cycle mem_req&mem_ack=1
- mem_ack  in  1  completes the access in the cycle it is high with mem_req
- alu_a  out  8  accumulator
- alu_b  out  8  operand register
- alu_select  out  3  opcode[2:0] during EXEC, else 0
- alu_out  in  8  alu result
- alu_zero, alu_carry, alu_neg  in  1 each  alu flags
- acc  out  8  accumulator (debug)
- pc  out  ADDR_W  program counter (debug)
- flags  out  3  {neg, carry, zero}, registered
- halted  out  1  high in HALT state
- illegal  out  1  one-cycle pulse on an undefined opcode

Behaviour:
- Reset: rst_n is sampled on the clk edge.
  - State = FETCH_OP, pc = RESET_PC.
  - acc, operand, IR, flags = 0.
  - mem_req, mem_we, halted, illegal = 0.
  - Reset mid-access abandons the transfer; mem_req is 0 in the cycle after the reset edge.
- Opcode byte [7:4] class, [2:0] alu select:
  - 0x0 NOP
  - 0x1 LDA a: acc = mem[a]
  - 0x2 LDI i: acc = i
  - 0x3 STA a: mem[a] = acc
  - 0x4 ALUM a: acc = alu(acc, mem[a])
  - 0x5 ALUI i: acc = alu(acc, i)
  - 0x6 JMP a
  - 0x7 JZ a
  - 0x8 JC a
  - 0x9 JN a
  - 0xF HALT
  - 0xA–0xE: illegal; pulse illegal, treat as a 1-byte NOP.
- 1-byte instructions: NOP, HALT, illegal. All others carry an argument byte at pc+1.
- States:
  - FETCH_OP: read mem[pc]. On ack: IR = rdata, pc += 1; go to FETCH_ARG (2-byte) or EXEC.
  - FETCH_ARG: read mem[pc]. On ack: operand = rdata, pc += 1. Then LDA/ALUM -> MEM_RD, STA -> MEM_WR, else -> EXEC.
  - MEM_RD: read mem[operand]. On ack: operand = rdata; go to EXEC.
  - MEM_WR: write acc to mem[operand]. On ack: go to FETCH_OP.
  - EXEC: exactly one cycle.
    - LDA/LDI: acc = operand; flags unchanged.
    - ALUM/ALUI: acc = alu_out; flags = {alu_neg, alu_carry, alu_zero}.
    - Jumps: pc = operand[ADDR_W-1:0] if the condition holds on the registered flags.
    - HALT: go to HALT.
    - Otherwise go to FETCH_OP.
  - HALT: absorbing until reset. mem_req = 0, halted = 1.
- Handshake:
  - mem_req/addr/we/wdata are asserted in the first cycle of a memory state and held stable until the cycle where mem_ack=1.
  - mem_req drops the following cycle unless the next state also accesses memory, in which case it stays high with the new address.
  - Zero-wait ack (ack high in the first req cycle) gives one cycle per access.
  - mem_ack while mem_req=0 is ignored.
- PC increments wrap modulo 2^ADDR_W. An argument fetch at the top address wraps to 0.
- Zero-wait cycle counts:
  - NOP/HALT: 2
  - LDI/ALUI/jumps: 3
  - STA: 3
  - LDA/ALUM: 4

Decomposition:
- Shared package acc_pkg:
  - opcode class localparams (OP_NOP..OP_HALT)
  - state encoding localparams
  - flag bit indices (FLAG_Z=0, FLAG_C=1, FLAG_N=2)
- One natural sub-module, acc_mem_port: holds the registered req/addr/we/wdata and reports done = req&ack.

Test Plan:
- Reset, then memory {0x20,0x0A, 0x50,0x14, 0xF0} with zero-wait ack and alu select 0 = add -> acc=30, flags=000, halted=1 after 8 cycles, pc=5.
- LDI 30; ALUI sel 1 (sub) 30; JZ 0x10; program at 0x10 = HALT -> flags.zero=1, pc jumps to 0x10, halted=1.
- STA with mem_ack delayed 3 cycles -> mem_req=1, mem_we=1, mem_addr/mem_wdata stable for 4 cycles, then mem_req falls.
- Opcode 0xB0 -> illegal pulses for exactly one cycle, pc advances by 1, acc and flags unchanged.
- rst_n low during a pending MEM_RD (ack withheld) -> next cycle mem_req=0, pc=RESET_PC, acc=0.
- ADDR_W=4, JMP 0x0F, then LDI at 0xF with its argument at 0x0 -> argument fetched from address 0, pc=1 afterwards.
